// File: rtl/mread_ctrl.sv
// Load sequencer: accepts one load, issues a word-aligned bus read, extends the addressed lane.
// Latency: accept -> req one cycle; result one cycle after response. Stall is high while a load is in flight.
module mread_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cushion_mem_r_valid,
  input  logic [4:0]        cushion_mem_r_rd,
  input  logic [ADDR_W-1:0] cushion_mem_r_addr,
  input  logic [3:0]        cushion_mem_r_strb,
  input  logic              cushion_mem_r_signed,
  output logic              mread_ready,
  output logic              mread_stall,
  output logic              mem_rd_req_valid,
  input  logic              mem_rd_req_ready,
  output logic [ADDR_W-1:0] mem_rd_req_addr,
  input  logic              mem_rd_resp_valid,
  input  logic [31:0]       mem_rd_resp_data,
  input  logic              mem_rd_resp_err,
  output logic              mread_reg_w_valid,
  output logic [4:0]        mread_reg_w_rd,
  output logic [31:0]       mread_reg_w_data,
  output logic              mread_err_valid,
  output logic [ADDR_W-1:0] mread_err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        strb_q;
  logic              sgn_q;

  logic              accept, legal, handshake, latch;
  logic              req_vld_nxt, regw_vld_nxt, err_vld_nxt;
  logic [ADDR_W-1:0] err_addr_nxt;
  logic [31:0]       lane, ext_data;

  assign mread_ready     = (state == IDLE) && !flush;
  assign mread_stall     = (state != IDLE);
  assign accept          = mread_ready && cushion_mem_r_valid;
  assign handshake       = mem_rd_req_valid && mem_rd_req_ready;
  assign mem_rd_req_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    legal = 1'b0;
    case (cushion_mem_r_strb)
      4'b0001: legal = 1'b1;
      4'b0011: legal = !cushion_mem_r_addr[0];
      4'b1111: legal = (cushion_mem_r_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    lane     = mem_rd_resp_data >> {addr_q[1:0], 3'b000};
    ext_data = lane;
    case (strb_q)
      4'b0001: ext_data = {{24{sgn_q & lane[7]}}, lane[7:0]};
      4'b0011: ext_data = {{16{sgn_q & lane[15]}}, lane[15:0]};
      default: ext_data = lane;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    latch        = 1'b0;
    regw_vld_nxt = 1'b0;
    err_vld_nxt  = 1'b0;
    err_addr_nxt = mread_err_addr;
    case (state)
      IDLE: begin
        if (accept) begin
          latch = 1'b1;
          if (legal) begin
            state_nxt = REQ;
          end else begin
            err_vld_nxt  = 1'b1;
            err_addr_nxt = cushion_mem_r_addr;
          end
        end
      end
      REQ: begin
        if (flush)          state_nxt = handshake ? DRAIN : IDLE;
        else if (handshake) state_nxt = WAIT;
      end
      WAIT: begin
        // A response coinciding with a flush is simply dropped; draining would wait forever.
        if (mem_rd_resp_valid) begin
          state_nxt = IDLE;
          if (!flush) begin
            if (mem_rd_resp_err) begin
              err_vld_nxt  = 1'b1;
              err_addr_nxt = addr_q;
            end else begin
              regw_vld_nxt = (rd_q != 5'd0);
            end
          end
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rd_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    req_vld_nxt = (state_nxt == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      rd_q              <= '0;
      addr_q            <= '0;
      strb_q            <= '0;
      sgn_q             <= 1'b0;
      mem_rd_req_valid  <= 1'b0;
      mread_reg_w_valid <= 1'b0;
      mread_reg_w_rd    <= '0;
      mread_reg_w_data  <= '0;
      mread_err_valid   <= 1'b0;
      mread_err_addr    <= '0;
    end else begin
      state             <= state_nxt;
      mem_rd_req_valid  <= req_vld_nxt;
      mread_reg_w_valid <= regw_vld_nxt;
      mread_err_valid   <= err_vld_nxt;
      mread_err_addr    <= err_addr_nxt;
      if (latch) begin
        rd_q   <= cushion_mem_r_rd;
        addr_q <= cushion_mem_r_addr;
        strb_q <= cushion_mem_r_strb;
        sgn_q  <= cushion_mem_r_signed;
      end
      if (regw_vld_nxt) begin
        mread_reg_w_rd   <= rd_q;
        mread_reg_w_data <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_mread_ctrl.sv
// Bench for mread_ctrl: directed load scenarios plus randomized loads against an arithmetic reference model.
module tb_mread_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_addr = '0;
  logic [3:0]  in_strb = '0;
  logic        in_sgn = 1'b0;
  logic        mread_ready, mread_stall, mem_rd_req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_err = 1'b0;
  logic        regw_valid;
  logic [4:0]  regw_rd;
  logic [31:0] regw_data;
  logic        err_valid;
  logic [31:0] err_addr;

  int total = 0;
  int bad = 0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_err_addr = '0;

  mread_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cushion_mem_r_valid(in_valid), .cushion_mem_r_rd(in_rd), .cushion_mem_r_addr(in_addr),
    .cushion_mem_r_strb(in_strb), .cushion_mem_r_signed(in_sgn),
    .mread_ready(mread_ready), .mread_stall(mread_stall),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(req_ready), .mem_rd_req_addr(req_addr),
    .mem_rd_resp_valid(resp_valid), .mem_rd_resp_data(resp_data), .mem_rd_resp_err(resp_err),
    .mread_reg_w_valid(regw_valid), .mread_reg_w_rd(regw_rd), .mread_reg_w_data(regw_data),
    .mread_err_valid(err_valid), .mread_err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Access size in bytes from the strobe code; 0 means an unsupported code.
  function automatic int size_of(input logic [3:0] strb);
    if (strb == 4'b0001) return 1;
    if (strb == 4'b0011) return 2;
    if (strb == 4'b1111) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] addr, input logic [3:0] strb,
                                        input logic sgn, input logic [31:0] data);
    longint unsigned v, span;
    int nb;
    nb   = size_of(strb);
    v    = longint'(data) / (64'd1 << (8 * (addr % 4)));
    span = 64'd1 << (8 * nb);
    v    = v % span;
    if (sgn && nb < 4 && v >= span / 2) v = v + (64'd1 << 32) - span;
    return v[31:0];
  endfunction

  task automatic drive_req(input logic [4:0] rd, input logic [31:0] addr,
                           input logic [3:0] strb, input logic sgn);
    in_valid = 1'b1; in_rd = rd; in_addr = addr; in_strb = strb; in_sgn = sgn;
  endtask

  // Accept a legal request and complete the bus handshake with no wait; leaves the DUT waiting for data.
  task automatic issue(input logic [4:0] rd, input logic [31:0] addr,
                       input logic [3:0] strb, input logic sgn);
    drive_req(rd, addr, strb, sgn);
    tick();
    in_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] strb,
                         input logic sgn, input logic [31:0] data, input logic err,
                         input int rdy_dly, input int resp_dly);
    int nb;
    logic legal, wexp;
    nb    = size_of(strb);
    legal = (nb != 0) && ((addr % nb) == 0);
    drive_req(rd, addr, strb, sgn);
    #1;
    chk("ready_idle", mread_ready, 1);
    tick();
    in_valid = 1'b0;
    if (!legal) begin
      exp_err_addr = addr;
      chk("misalign_err_vld", err_valid, 1);
      chk("misalign_err_addr", err_addr, exp_err_addr);
      chk("misalign_no_req", mem_rd_req_valid, 0);
      chk("misalign_no_regw", regw_valid, 0);
      chk("misalign_no_stall", mread_stall, 0);
      tick();
      chk("misalign_err_pulse", err_valid, 0);
      return;
    end
    chk("req_vld_first", mem_rd_req_valid, 1);
    chk("req_addr", req_addr, addr - (addr % 4));
    chk("stall_req", mread_stall, 1);
    for (int i = 0; i < rdy_dly; i++) begin
      resp_valid = 1'($urandom_range(0, 1));
      resp_data  = $urandom;
      tick();
      resp_valid = 1'b0;
      chk("req_vld_held", mem_rd_req_valid, 1);
      chk("req_addr_held", req_addr, addr - (addr % 4));
      chk("no_regw_in_req", regw_valid, 0);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("req_vld_drop", mem_rd_req_valid, 0);
    chk("stall_wait", mread_stall, 1);
    for (int i = 0; i < resp_dly; i++) begin
      tick();
      chk("stall_wait_hold", mread_stall, 1);
      chk("no_regw_in_wait", regw_valid, 0);
    end
    resp_valid = 1'b1; resp_data = data; resp_err = err;
    tick();
    resp_valid = 1'b0; resp_err = 1'b0;
    wexp = !err && (rd != 5'd0);
    if (wexp) begin
      exp_rd   = rd;
      exp_data = model(addr, strb, sgn, data);
    end
    if (err) exp_err_addr = addr;
    chk("regw_vld", regw_valid, wexp);
    chk("err_vld", err_valid, err);
    chk("regw_rd", regw_rd, exp_rd);
    chk("regw_data", regw_data, exp_data);
    chk("err_addr", err_addr, exp_err_addr);
    chk("stall_done", mread_stall, 0);
    tick();
    chk("regw_pulse", regw_valid, 0);
    chk("err_pulse", err_valid, 0);
    chk("regw_data_hold", regw_data, exp_data);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_ready", mread_ready, 1);
    chk("rst_stall", mread_stall, 0);
    chk("rst_req_vld", mem_rd_req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_regw_vld", regw_valid, 0);
    chk("rst_regw_rd", regw_rd, 0);
    chk("rst_regw_data", regw_data, 0);
    chk("rst_err_vld", err_valid, 0);
    chk("rst_err_addr", err_addr, 0);
    rst = 1'b1;
    tick();

    // LB signed, top byte lane
    do_load(5'd5, 32'h1003, 4'b0001, 1'b1, 32'h8011_2233, 1'b0, 0, 0);
    chk("lb_signed_value", regw_data, 32'hFFFF_FF80);
    // LHU upper half
    do_load(5'd7, 32'h2002, 4'b0011, 1'b0, 32'hBEEF_1234, 1'b0, 0, 1);
    chk("lhu_value", regw_data, 32'h0000_BEEF);
    // LW with three cycles of bus backpressure
    do_load(5'd9, 32'h3000, 4'b1111, 1'b0, 32'hCAFE_F00D, 1'b0, 3, 0);
    chk("lw_value", regw_data, 32'hCAFE_F00D);
    // Misaligned word
    do_load(5'd9, 32'h3002, 4'b1111, 1'b0, 32'h0, 1'b0, 0, 0);
    // Unsupported strobe code
    do_load(5'd3, 32'h4000, 4'b0111, 1'b0, 32'h0, 1'b0, 0, 0);
    // Bus error
    do_load(5'd4, 32'h5004, 4'b1111, 1'b1, 32'h1234_5678, 1'b1, 1, 2);

    // Flush while IDLE blocks acceptance, even of an illegal request
    drive_req(5'd1, 32'h3002, 4'b1111, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", mread_ready, 0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_req", mem_rd_req_valid, 0);
    chk("flush_idle_no_err", err_valid, 0);

    // Flush in REQ before the handshake
    drive_req(5'd2, 32'h6000, 4'b1111, 1'b0);
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_req_vld", mem_rd_req_valid, 0);
    chk("flush_req_stall", mread_stall, 0);

    // Flush in the handshake cycle: the response must be drained silently
    drive_req(5'd2, 32'h6000, 4'b1111, 1'b0);
    tick();
    in_valid = 1'b0; flush = 1'b1; req_ready = 1'b1;
    tick();
    flush = 1'b0; req_ready = 1'b0;
    chk("flush_hs_req_vld", mem_rd_req_valid, 0);
    chk("flush_hs_stall", mread_stall, 1);
    resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    chk("flush_hs_no_regw", regw_valid, 0);
    chk("flush_hs_idle", mread_stall, 0);

    // Flush in WAIT, response two cycles later
    issue(5'd6, 32'h7001, 4'b0001, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_wait_stall", mread_stall, 1);
    tick();
    resp_valid = 1'b1; resp_data = 32'h1111_1111; resp_err = 1'b1;
    tick();
    resp_valid = 1'b0; resp_err = 1'b0;
    chk("flush_wait_no_regw", regw_valid, 0);
    chk("flush_wait_no_err", err_valid, 0);
    chk("flush_wait_idle", mread_stall, 0);
    do_load(5'd6, 32'h7001, 4'b0001, 1'b0, 32'h0000_A500, 1'b0, 0, 0);
    chk("after_flush_lbu", regw_data, 32'h0000_00A5);

    // Asynchronous reset while waiting for data
    issue(5'd8, 32'h8000, 4'b1111, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    exp_rd = '0; exp_data = '0; exp_err_addr = '0;
    chk("arst_stall", mread_stall, 0);
    chk("arst_req_vld", mem_rd_req_valid, 0);
    chk("arst_req_addr", req_addr, 0);
    chk("arst_regw_rd", regw_rd, 0);
    chk("arst_regw_data", regw_data, 0);
    chk("arst_err_addr", err_addr, 0);
    tick();
    rst = 1'b1;
    resp_valid = 1'b1; resp_data = 32'h5555_AAAA;
    tick();
    resp_valid = 1'b0;
    chk("late_resp_no_regw", regw_valid, 0);
    chk("late_resp_no_err", err_valid, 0);
    do_load(5'd0, 32'h9002, 4'b0011, 1'b1, 32'h8000_0000, 1'b0, 0, 0);

    // Randomized loads
    for (int n = 0; n < 80; n++) begin
      logic [3:0] strb;
      case ($urandom_range(0, 7))
        0, 1:    strb = 4'b0001;
        2, 3:    strb = 4'b0011;
        4, 5:    strb = 4'b1111;
        default: strb = 4'($urandom);
      endcase
      do_load(5'($urandom_range(0, 31)), $urandom, strb, 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
